rvc_packer: RTL and testbench



---
 rtl/rvc_packer.sv | 173 +++++++++++++++++
 tb/tb_rvc_packer.sv | 387 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvc_packer.sv
// rvc_packer: re-encodes RV32I instructions as RVC parcels where an exact equivalent
// exists and packs parcels little-endian into 32-bit words. RVC_PACK_CTRL_EN adds JAL/JALR/BEQ/BNE.
module rvc_packer #(
    parameter int CTRL_CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [31:0]           in_instr_i,
    input  logic                  flush_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           out_word_o,
    output logic                  illegal_o,
    output logic                  idle_o,
    output logic [CTRL_CNT_W-1:0] cmp_cnt_o
);

    logic [15:0]           pend_q;
    logic                  pend_v;
    logic [31:0]           out_q;
    logic                  out_v;
    logic                  illegal_q;
    logic [CTRL_CNT_W-1:0] cnt_q;

    logic        slot_free, accept, legal, is_c;
    logic [15:0] c_enc;

    assign slot_free  = !out_v || out_ready_i;
    assign in_ready_o = slot_free && !flush_i;
    assign accept     = in_valid_i && in_ready_o;
    assign legal      = (in_instr_i[1:0] == 2'b11);

    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm_i, imm_s;
    logic        is_addi, is_add, is_lw, is_sw, imm6_ok;
    logic        rd_c, rs1_c, rs2_c, lw_sp_ok, sw_sp_ok, lw_c_ok, sw_c_ok;

    assign opc   = in_instr_i[6:0];
    assign rd    = in_instr_i[11:7];
    assign f3    = in_instr_i[14:12];
    assign rs1   = in_instr_i[19:15];
    assign rs2   = in_instr_i[24:20];
    assign f7    = in_instr_i[31:25];
    assign imm_i = in_instr_i[31:20];
    assign imm_s = {in_instr_i[31:25], in_instr_i[11:7]};

    assign is_addi = (opc == 7'h13) && (f3 == 3'b000);
    assign is_add  = (opc == 7'h33) && (f3 == 3'b000) && (f7 == 7'h00);
    assign is_lw   = (opc == 7'h03) && (f3 == 3'b010);
    assign is_sw   = (opc == 7'h23) && (f3 == 3'b010);
    assign imm6_ok = (imm_i[11:5] == 7'h00) || (imm_i[11:5] == 7'h7f);

    // x8..x15 are the only registers reachable through the 3-bit RVC fields
    assign rd_c  = (rd[4:3] == 2'b01);
    assign rs1_c = (rs1[4:3] == 2'b01);
    assign rs2_c = (rs2[4:3] == 2'b01);

    assign lw_sp_ok = (imm_i[11:8] == 4'h0) && (imm_i[1:0] == 2'b00);
    assign sw_sp_ok = (imm_s[11:8] == 4'h0) && (imm_s[1:0] == 2'b00);
    assign lw_c_ok  = (imm_i[11:7] == 5'h00) && (imm_i[1:0] == 2'b00);
    assign sw_c_ok  = (imm_s[11:7] == 5'h00) && (imm_s[1:0] == 2'b00);

`ifdef RVC_PACK_CTRL_EN
    logic [20:1] j_imm;
    logic [12:1] b_imm;
    logic        j_ok, b_ok;

    assign j_imm = {in_instr_i[31], in_instr_i[19:12], in_instr_i[20], in_instr_i[30:21]};
    assign b_imm = {in_instr_i[31], in_instr_i[7], in_instr_i[30:25], in_instr_i[11:8]};
    assign j_ok  = (j_imm[20:11] == 10'h000) || (j_imm[20:11] == 10'h3ff);
    assign b_ok  = (b_imm[12:8] == 5'h00) || (b_imm[12:8] == 5'h1f);
`endif

    always_comb begin
        is_c  = 1'b0;
        c_enc = 16'h0000;
        if (in_instr_i == 32'h0010_0073) begin
            is_c  = 1'b1;
            c_enc = 16'h9002;
        end else if (is_addi && rd == 5'd0 && rs1 == 5'd0 && imm_i == 12'h000) begin
            is_c  = 1'b1;
            c_enc = 16'h0001;
        end else if (is_addi && rd != 5'd0 && rs1 == 5'd0 && imm6_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b010, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_addi && rd != 5'd0 && rs1 == rd && imm_i != 12'h000 && imm6_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b000, imm_i[5], rd, imm_i[4:0], 2'b01};
        end else if (is_add && rd != 5'd0 && rs1 == 5'd0 && rs2 != 5'd0) begin
            is_c  = 1'b1;
            c_enc = {4'b1000, rd, rs2, 2'b10};
        end else if (is_add && rd != 5'd0 && rs1 == rd && rs2 != 5'd0) begin
            is_c  = 1'b1;
            c_enc = {4'b1001, rd, rs2, 2'b10};
        end else if (is_lw && rd != 5'd0 && rs1 == 5'd2 && lw_sp_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], 2'b10};
        end else if (is_sw && rs1 == 5'd2 && sw_sp_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b110, imm_s[5:2], imm_s[7:6], rs2, 2'b10};
        end else if (is_lw && rd_c && rs1_c && lw_c_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], 2'b00};
        end else if (is_sw && rs2_c && rs1_c && sw_c_ok) begin
            is_c  = 1'b1;
            c_enc = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], 2'b00};
`ifdef RVC_PACK_CTRL_EN
        end else if (opc == 7'h6f && rd[4:1] == 4'h0 && j_ok) begin
            is_c  = 1'b1;
            c_enc = {~rd[0], 2'b01, j_imm[11], j_imm[4], j_imm[9:8], j_imm[10], j_imm[6],
                     j_imm[7], j_imm[3:1], j_imm[5], 2'b01};
        end else if (opc == 7'h67 && f3 == 3'b000 && imm_i == 12'h000 && rd[4:1] == 4'h0
                     && rs1 != 5'd0) begin
            is_c  = 1'b1;
            c_enc = {3'b100, rd[0], rs1, 5'd0, 2'b10};
        end else if (opc == 7'h63 && f3[2:1] == 2'b00 && rs2 == 5'd0 && rs1_c && b_ok) begin
            is_c  = 1'b1;
            c_enc = {2'b11, f3[0], b_imm[8], b_imm[4:3], rs1[2:0], b_imm[7:6], b_imm[2:1],
                     b_imm[5], 2'b01};
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pend_q    <= '0;
            pend_v    <= 1'b0;
            out_q     <= '0;
            out_v     <= 1'b0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            illegal_q <= accept && !legal;
            if (out_ready_i) out_v <= 1'b0;
            if (accept && legal) begin
                if (is_c) cnt_q <= cnt_q + CTRL_CNT_W'(1);
                if (!pend_v) begin
                    if (is_c) begin
                        pend_q <= c_enc;
                        pend_v <= 1'b1;
                    end else begin
                        out_q <= in_instr_i;
                        out_v <= 1'b1;
                    end
                end else if (is_c) begin
                    out_q  <= {c_enc, pend_q};
                    out_v  <= 1'b1;
                    pend_v <= 1'b0;
                end else begin
                    // 32-bit instruction straddles the word boundary; upper half stays pending
                    out_q  <= {in_instr_i[15:0], pend_q};
                    out_v  <= 1'b1;
                    pend_q <= in_instr_i[31:16];
                end
            end else if (flush_i && pend_v && slot_free) begin
                out_q  <= {16'h0001, pend_q};
                out_v  <= 1'b1;
                pend_v <= 1'b0;
            end
        end
    end

    assign out_valid_o = out_v;
    assign out_word_o  = out_q;
    assign illegal_o   = illegal_q;
    assign idle_o      = !pend_v && !out_v;
    assign cmp_cnt_o   = cnt_q;

endmodule

// File: tb/tb_rvc_packer.sv
// Scoreboard bench for rvc_packer: reference built from an RVC expander table and a parcel queue.
module tb_rvc_packer;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          in_valid_i = 1'b0;
    logic [31:0]   in_instr_i = 32'h0;
    logic          flush_i = 1'b0;
    logic          out_ready_i = 1'b1;
    logic          in_ready_o, out_valid_o, illegal_o, idle_o;
    logic [31:0]   out_word_o;
    logic [CW-1:0] cmp_cnt_o;

    always #5 clk = ~clk;

    rvc_packer #(.CTRL_CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_instr_i(in_instr_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i), .out_word_o(out_word_o), .illegal_o(illegal_o),
        .idle_o(idle_o), .cmp_cnt_o(cmp_cnt_o)
    );

    typedef struct { logic [31:0] word; int cyc; } exp_t;

    int          n_chk = 0, n_fail = 0, cyc = 0;
    bit          rnd_mode = 1'b0;
    exp_t        exp_q[$];
    logic [31:0] got_log[$];
    logic [15:0] m_par[$];
    int          m_cnt = 0;
    logic        m_ill = 1'b0;
    logic [15:0] cmap [logic [31:0]];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk_i(int imm, int rs1, int f3, int rd, logic [6:0] op);
        logic [11:0] i = imm[11:0];
        return {i, 5'(rs1), 3'(f3), 5'(rd), op};
    endfunction
    function automatic logic [31:0] mk_s(int imm, int rs2, int rs1);
        logic [11:0] s = imm[11:0];
        return {s[11:5], 5'(rs2), 5'(rs1), 3'b010, s[4:0], 7'h23};
    endfunction
    function automatic logic [31:0] mk_r(int f7, int rs2, int rs1, int f3, int rd);
        return {7'(f7), 5'(rs2), 5'(rs1), 3'(f3), 5'(rd), 7'h33};
    endfunction
    function automatic logic [31:0] mk_j(int imm, int rd);
        logic [20:0] j = imm[20:0];
        return {j[20], j[10:1], j[11], j[19:12], 5'(rd), 7'h6f};
    endfunction
    function automatic logic [31:0] mk_b(int imm, int rs2, int rs1, int f3);
        logic [12:0] b = imm[12:0];
        return {b[12], b[10:5], 5'(rs2), 5'(rs1), 3'(f3), b[4:1], b[11], 7'h63};
    endfunction

    // RVC expander restricted to the forms the packer may produce
    function automatic bit expand(input logic [15:0] p, output logic [31:0] w);
        int rd   = int'(p[11:7]);
        int rs2  = int'(p[6:2]);
        int f3   = int'(p[15:13]);
        int q    = int'(p[1:0]);
        int imm6 = p[12] ? int'(p[6:2]) - 32 : int'(p[6:2]);
        int off;
        w = 32'h0;
        if (q == 1 && f3 == 0) begin
            if (p == 16'h0001) begin w = mk_i(0, 0, 0, 0, 7'h13); return 1'b1; end
            if (rd != 0 && imm6 != 0) begin w = mk_i(imm6, rd, 0, rd, 7'h13); return 1'b1; end
        end
        if (q == 1 && f3 == 2 && rd != 0) begin w = mk_i(imm6, 0, 0, rd, 7'h13); return 1'b1; end
        if (q == 2 && f3 == 4) begin
            if (p[12] && rd == 0 && rs2 == 0) begin w = 32'h0010_0073; return 1'b1; end
            if (rd != 0 && rs2 != 0) begin
                w = mk_r(0, rs2, p[12] ? rd : 0, 0, rd);
                return 1'b1;
            end
`ifdef RVC_PACK_CTRL_EN
            if (rd != 0 && rs2 == 0) begin
                w = mk_i(0, rd, 0, p[12] ? 1 : 0, 7'h67);
                return 1'b1;
            end
`endif
        end
        if (q == 2 && f3 == 2 && rd != 0) begin
            off = int'(p[3:2]) * 64 + int'(p[12]) * 32 + int'(p[6:4]) * 4;
            w = mk_i(off, 2, 2, rd, 7'h03);
            return 1'b1;
        end
        if (q == 2 && f3 == 6) begin
            off = int'(p[8:7]) * 64 + int'(p[12:9]) * 4;
            w = mk_s(off, rs2, 2);
            return 1'b1;
        end
        if (q == 0 && (f3 == 2 || f3 == 6)) begin
            off = int'(p[5]) * 64 + int'(p[12:10]) * 8 + int'(p[6]) * 4;
            if (f3 == 2) w = mk_i(off, 8 + int'(p[9:7]), 2, 8 + int'(p[4:2]), 7'h03);
            else         w = mk_s(off, 8 + int'(p[4:2]), 8 + int'(p[9:7]));
            return 1'b1;
        end
`ifdef RVC_PACK_CTRL_EN
        if (q == 1 && (f3 == 1 || f3 == 5)) begin
            off = (p[12] ? -2048 : 0) + int'(p[8]) * 1024 + int'(p[10:9]) * 256 + int'(p[6]) * 128
                + int'(p[7]) * 64 + int'(p[2]) * 32 + int'(p[11]) * 16 + int'(p[5:3]) * 2;
            w = mk_j(off, f3 == 1 ? 1 : 0);
            return 1'b1;
        end
        if (q == 1 && (f3 == 6 || f3 == 7)) begin
            off = (p[12] ? -256 : 0) + int'(p[6:5]) * 64 + int'(p[2]) * 32 + int'(p[11:10]) * 8
                + int'(p[4:3]) * 2;
            w = mk_b(off, 0, 8 + int'(p[9:7]), f3 == 6 ? 0 : 1);
            return 1'b1;
        end
`endif
        return 1'b0;
    endfunction

    task automatic exp_push(input logic [31:0] w);
        exp_t e;
        e.word = w;
        e.cyc  = cyc;
        exp_q.push_back(e);
    endtask

    task automatic m_take(input logic [31:0] ins);
        if (cmap.exists(ins)) begin
            m_par.push_back(cmap[ins]);
            m_cnt++;
        end else begin
            m_par.push_back(ins[15:0]);
            m_par.push_back(ins[31:16]);
        end
        while (m_par.size() >= 2) begin
            exp_push({m_par[1], m_par[0]});
            m_par.delete(0);
            m_par.delete(0);
        end
    endtask

    // reference model: compare current state, then apply the coming clock edge
    always @(negedge clk) begin : model_p
        bit slot;
        if (rst_i) begin
            m_par.delete();
            exp_q.delete();
            m_cnt = 0;
            m_ill = 1'b0;
        end else begin
            chk("in_ready", in_ready_o, (!out_valid_o || out_ready_i) && !flush_i);
            chk("illegal", illegal_o, m_ill);
            chk("cmp_cnt", cmp_cnt_o, CW'(m_cnt));
            chk("idle", idle_o, (m_par.size() == 0) && !out_valid_o);
            m_ill = 1'b0;
            slot  = !out_valid_o || out_ready_i;
            if (in_valid_i && slot && !flush_i) begin
                if (in_instr_i[1:0] != 2'b11) m_ill = 1'b1;
                else m_take(in_instr_i);
            end else if (flush_i && slot && m_par.size() == 1) begin
                exp_push({16'h0001, m_par[0]});
                m_par.delete();
            end
        end
    end

    always @(negedge clk) begin : monitor_p
        logic        prev_stall;
        logic [31:0] prev_word;
        exp_t        e;
        if (rst_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("hold_valid", out_valid_o, 1'b1);
                chk("hold_word", out_word_o, prev_word);
            end
            if (out_valid_o) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", out_word_o, 32'hxxxx_xxxx);
                end else begin
                    if (!prev_stall) chk("latency", cyc, exp_q[0].cyc + 1);
                    if (out_ready_i) begin
                        e = exp_q.pop_front();
                        chk("word", out_word_o, e.word);
                        got_log.push_back(out_word_o);
                    end
                end
            end
            prev_stall = out_valid_o && !out_ready_i;
            prev_word  = out_word_o;
        end
    end

    always @(posedge clk) begin
        #1;
        if (rnd_mode) begin
            out_ready_i = ($urandom_range(0, 3) != 0);
            flush_i     = ($urandom_range(0, 9) == 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] ins);
        bit a;
        int n = 0;
        in_valid_i = 1'b1;
        in_instr_i = ins;
        do begin
            @(negedge clk);
            a = in_ready_o;
            tick();
            n++;
        end while (!a && n < 64);
        if (!a) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_timeout: instr %h not accepted within %0d cycles", ins, n);
        end
        in_valid_i = 1'b0;
    endtask

    function automatic logic [31:0] last_word();
        if (got_log.size() == 0) return 32'hxxxx_xxxx;
        return got_log[got_log.size() - 1];
    endfunction

    function automatic int pick(int a, int b, int c);
        int k = $urandom_range(0, 2);
        return (k == 0) ? a : (k == 1) ? b : c;
    endfunction

    function automatic logic [31:0] rnd_instr();
        int k   = $urandom_range(0, 19);
        int rd  = $urandom_range(0, 31);
        int rs2 = $urandom_range(0, 31);
        int rc  = 8 + $urandom_range(0, 7);
        int imm = $urandom_range(0, 1) ? $urandom_range(0, 80) - 40 : $urandom_range(0, 4095) - 2048;
        int mo  = pick(4 * $urandom_range(0, 70), 4 * $urandom_range(0, 35), $urandom_range(0, 4095) - 2048);
        logic [31:0] w;
        case (k)
            0, 1, 2, 18, 19: w = mk_i(imm, pick(0, rd, $urandom_range(0, 31)), 0, rd, 7'h13);
            3, 4:   w = mk_r($urandom_range(0, 5) == 0 ? 32 : 0, rs2, pick(0, rd, $urandom_range(0, 31)),
                             $urandom_range(0, 3) == 0 ? 1 : 0, rd);
            5, 6:   w = mk_i(mo, pick(2, rc, $urandom_range(0, 31)), 2, pick(rd, 8 + $urandom_range(0, 7), 0), 7'h03);
            7, 8:   w = mk_s(mo, pick(rs2, 8 + $urandom_range(0, 7), 0), pick(2, rc, $urandom_range(0, 31)));
            9:      w = pick(32'h0010_0073, 32'h0000_0073, pick(32'h0000_0013, 32'h0010_0013, 32'h0000_0033));
            10, 11: w = mk_j(2 * ($urandom_range(0, 1) ? $urandom_range(0, 2100) - 1050 : $urandom_range(0, 1 << 19) - (1 << 18)),
                             pick(0, 1, rd));
            12:     w = mk_i(pick(0, 0, 4), $urandom_range(0, 31), 0, pick(0, 1, rd), 7'h67);
            13, 14: w = mk_b(2 * ($urandom_range(0, 300) - 150), pick(0, 0, rs2), pick(rc, rc, rd), pick(0, 1, 4));
            15, 16: w = {$urandom()} | 32'h3;
            default: begin
                w = $urandom();
                w[1:0] = 2'($urandom_range(0, 2));
            end
        endcase
        return w;
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        int          sz;
        for (int p = 0; p < 65536; p++)
            if (expand(16'(p), w)) cmap[w] = 16'(p);

        tick();
        tick();
        @(negedge clk);
        chk("rst_out_valid", out_valid_o, 1'b0);
        chk("rst_out_word", out_word_o, 32'h0);
        chk("rst_illegal", illegal_o, 1'b0);
        chk("rst_cmp_cnt", cmp_cnt_o, 32'h0);
        chk("rst_idle", idle_o, 1'b1);
        tick();
        rst_i = 1'b0;

        send(32'h0015_0513);
        send(32'h0050_0593);
        repeat (2) @(negedge clk);
        chk("tp_addi_li", last_word(), 32'h4595_0505);
        chk("tp_cnt2", cmp_cnt_o, 32'd2);
        tick();

        send(32'h1234_52B7);
        repeat (2) @(negedge clk);
        chk("tp_lui", last_word(), 32'h1234_52B7);
        chk("tp_cnt_lui", cmp_cnt_o, 32'd2);
        tick();

        send(32'h0015_0513);
        send(32'h1234_52B7);
        repeat (2) @(negedge clk);
        chk("tp_straddle", last_word(), 32'h52B7_0505);
        tick();
        flush_i = 1'b1;
        tick();
        tick();
        flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("tp_flush", last_word(), 32'h0001_1234);
        chk("tp_flush_idle", idle_o, 1'b1);
        tick();

        send(32'h0044_A403);
        send(32'h0000_0013);
        repeat (2) @(negedge clk);
        chk("tp_clw_nop", last_word(), 32'h0001_40C0);
        tick();

        out_ready_i = 1'b0;
        send(32'h1234_52B7);
        in_valid_i = 1'b1;
        in_instr_i = 32'hABCD_E537;
        repeat (3) begin
            @(negedge clk);
            chk("stall_ready", in_ready_o, 1'b0);
            chk("stall_word", out_word_o, 32'h1234_52B7);
            tick();
        end
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("release_ready", in_ready_o, 1'b1);
        tick();
        in_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("release_word", last_word(), 32'hABCD_E537);
        tick();

        send(32'h0000_0000);
        chk("illegal_pulse", illegal_o, 1'b1);
        tick();
        chk("illegal_clear", illegal_o, 1'b0);
        chk("illegal_idle", idle_o, 1'b1);

        send(32'h0015_0513);
        sz = got_log.size();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid_o, 1'b0);
        chk("mid_rst_idle", idle_o, 1'b1);
        tick();
        flush_i = 1'b1;
        repeat (3) tick();
        flush_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("mid_rst_no_word", got_log.size(), sz);
        tick();

        rnd_mode = 1'b1;
        repeat (800) begin
            send(rnd_instr());
            repeat ($urandom_range(0, 3) == 0 ? $urandom_range(1, 3) : 0) tick();
        end
        rnd_mode = 1'b0;
        tick();
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        repeat (3) tick();
        flush_i = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        chk("drain_idle", idle_o, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
